accumulator_feed_fifo: RTL and testbench

//   Upstream feeder for the 16-bit feedback accumulator stage: buffers input samples in a small FIFO.

---
 rtl/accumulator_feed_fifo.sv | 83 ++++++++
 tb/tb_accumulator_feed_fifo.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/accumulator_feed_fifo.sv
// Small FIFO feeding a free-running accumulator: at most one sample issued per clock,
// and out_data is held at zero whenever nothing is issued so the running sum is untouched.
module accumulator_feed_fifo #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              run,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              push, pop;

  // Status flags derive from the current occupancy only.
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = ~full;
  assign count    = count_q;
  assign out_data = out_data_q;
  assign out_valid = out_valid_q;

  assign push = in_valid & ~full;
  assign pop  = run & ~empty;

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    out_data_d  = '0;
    out_valid_d = 1'b0;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
    end
    // Issue reads the entry present before this edge, so a fresh push is never bypassed.
    if (pop) begin
      out_data_d  = mem_q[rd_ptr_q];
      out_valid_d = 1'b1;
      rd_ptr_d    = rd_ptr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Storage needs no reset; pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_accumulator_feed_fifo.sv
// Scoreboard bench: driver updates a queue model and pushes expected issues; monitor checks each edge.
module tb_accumulator_feed_fifo;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 2;

  logic              clk;
  logic              reset;
  logic [WIDTH-1:0]  in_data;
  logic              in_valid;
  logic              in_ready;
  logic              run;
  logic [WIDTH-1:0]  out_data;
  logic              out_valid;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;

  accumulator_feed_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .run(run), .out_data(out_data), .out_valid(out_valid), .count(count), .full(full),
    .empty(empty)
  );

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] model_q [$];
  logic [WIDTH-1:0] exp_q [$];
  bit               exp_valid = 1'b0;
  logic [WIDTH-1:0] acc_model = '0;
  logic [WIDTH-1:0] acc_dut = '0;

  initial begin
    clk = 1'b1;
    forever #50 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle and advance the reference model to the state after the coming edge.
  task automatic step(input bit r, input bit v, input logic [WIDTH-1:0] d, input bit rn);
    bit               can_push;
    bit               do_pop;
    logic [WIDTH-1:0] s;
    @(negedge clk);
    reset = r; in_valid = v; in_data = d; run = rn;
    if (r) begin
      model_q.delete();
      exp_valid = 1'b0;
    end else begin
      can_push  = model_q.size() < DEPTH;
      do_pop    = rn && (model_q.size() > 0);
      exp_valid = do_pop;
      if (do_pop) begin
        s = model_q.pop_front();
        exp_q.push_back(s);
        acc_model = acc_model + s;
      end
      if (v && can_push) model_q.push_back(d);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare every edge against the model, popping expected samples on out_valid.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      acc_dut = acc_dut + out_data;
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue: got %0d expected none at time %0t", out_data, $time);
        end else begin
          chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end else begin
        chk("idle_out_data", 32'(out_data), 32'(0));
      end
      chk("count", 32'(count), 32'(model_q.size()));
      chk("full", 32'(full), 32'(model_q.size() == DEPTH));
      chk("empty", 32'(empty), 32'(model_q.size() == 0));
      chk("in_ready", 32'(in_ready), 32'(model_q.size() < DEPTH));
      chk("acc", 32'(acc_dut), 32'(acc_model));
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; run = 1'b0;

    // Reset held with write and run requested: nothing stored.
    step(1, 1, 16'd5, 1);
    step(1, 1, 16'd5, 1);
    settle();
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_empty", 32'(empty), 32'(1));

    // Two pushes of 5 with run=1, then accumulator sum should reach 10.
    step(0, 1, 16'd5, 1);
    step(0, 1, 16'd5, 1);
    step(0, 0, 16'd0, 1);
    step(0, 0, 16'd0, 1);
    settle();
    chk("s2_acc", 32'(acc_dut), 32'(10));

    // Fill with run=0, then an attempted 5th write is blocked.
    for (int i = 1; i <= 4; i++) step(0, 1, WIDTH'(i), 0);
    step(0, 1, 16'd9, 0);
    settle();
    chk("s3_full", 32'(full), 32'(1));
    chk("s3_count", 32'(count), 32'(4));
    chk("s3_in_ready", 32'(in_ready), 32'(0));

    // Drain, then a push after pointer wrap.
    for (int i = 0; i < 5; i++) step(0, 0, 16'd0, 1);
    step(0, 1, 16'd200, 1);
    step(0, 0, 16'd0, 1);
    step(0, 0, 16'd0, 1);

    // Simultaneous push/pop at occupancy 1.
    step(0, 1, 16'd5, 0);
    step(0, 1, 16'd10, 1);
    step(0, 1, 16'd20, 1);
    step(0, 1, 16'd30, 1);
    settle();
    chk("s5_count", 32'(count), 32'(1));
    step(0, 0, 16'd0, 1);
    step(0, 0, 16'd0, 1);

    // Mid-operation reset flushes; the next pushed sample is the next issued.
    for (int i = 0; i < 3; i++) step(0, 1, WIDTH'(100 + i), 0);
    step(1, 0, 16'd0, 1);
    settle();
    chk("s6_count", 32'(count), 32'(0));
    step(0, 1, 16'd7, 1);
    step(0, 0, 16'd0, 1);
    step(0, 0, 16'd0, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
           WIDTH'($urandom), ($urandom_range(0, 3) != 0));
    end
    step(0, 0, 16'd0, 1);
    for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 16'd0, 1);
    settle();
    settle();
    chk("final_pending", 32'(exp_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
